// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller with a small register bank.
// Scans NUM_DIGITS digits at SCAN_DIV clocks per digit in hex-decode or raw-segment mode.
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  input  logic                  wr,
  input  logic                  rd,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int              PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [1:0]      IDX_LAST   = 2'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic                    en_r;
  logic                    mode_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic [NUM_DIGITS-1:0]   dp_mask_r;
  logic [4*NUM_DIGITS-1:0] hex_r;
  logic [8*NUM_DIGITS-1:0] raw_r;
  logic [PW-1:0]           presc_r;
  logic [1:0]              idx_r;

  logic [31:0]             ctrl_word_s;
  logic [31:0]             hex_word_s;
  logic [31:0]             raw_word_s;
  logic [31:0]             status_word_s;
  logic                    wr_ctrl_s;
  logic                    en_next_s;
  logic [3:0]              blank_ext_s;
  logic [3:0]              dp_ext_s;
  logic [3:0]              an_full_s;
  logic [3:0]              nibble_s;
  logic [7:0]              raw_byte_s;
  logic [NUM_DIGITS-1:0]   an_next_s;
  logic [6:0]              seg_next_s;
  logic                    dp_next_s;
  logic                    unused_s;

  // Zero-extended 32-bit views of the registers as seen on the bus.
  always_comb begin
    ctrl_word_s                       = 32'h0;
    ctrl_word_s[0]                    = en_r;
    ctrl_word_s[1]                    = mode_r;
    ctrl_word_s[8 +: NUM_DIGITS]      = blank_r;
    ctrl_word_s[16 +: NUM_DIGITS]     = dp_mask_r;
    hex_word_s                        = 32'h0;
    hex_word_s[4*NUM_DIGITS-1:0]      = hex_r;
    raw_word_s                        = 32'h0;
    raw_word_s[8*NUM_DIGITS-1:0]      = raw_r;
    status_word_s                     = 32'h0;
    status_word_s[1:0]                = idx_r;
    status_word_s[8]                  = en_r;
  end

  // Combinational read port; returns pre-write contents on a simultaneous write.
  always_comb begin
    data_out = 32'h0;
    if (rd) begin
      case (addr[3:2])
        2'd0:    data_out = ctrl_word_s;
        2'd1:    data_out = hex_word_s;
        2'd2:    data_out = raw_word_s;
        2'd3:    data_out = status_word_s;
        default: data_out = 32'h0;
      endcase
    end else begin
      data_out = 32'h0;
    end
  end

  // Register bank writes; STATUS is read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r      <= 1'b0;
      mode_r    <= 1'b0;
      blank_r   <= '0;
      dp_mask_r <= '0;
      hex_r     <= '0;
      raw_r     <= '0;
    end else if (wr) begin
      case (addr[3:2])
        2'd0: begin
          en_r      <= data_in[0];
          mode_r    <= data_in[1];
          blank_r   <= data_in[8 +: NUM_DIGITS];
          dp_mask_r <= data_in[16 +: NUM_DIGITS];
        end
        2'd1:    hex_r <= data_in[4*NUM_DIGITS-1:0];
        2'd2:    raw_r <= data_in[8*NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // A CTRL write clearing EN zeroes the counters on that same edge.
  always_comb begin
    wr_ctrl_s = wr && (addr[3:2] == 2'd0);
    if (wr_ctrl_s) begin
      en_next_s = data_in[0];
    end else begin
      en_next_s = en_r;
    end
  end

  // Prescaler and digit index; they only run while EN was already set.
  always_ff @(posedge clk) begin
    if (rst || !en_r || !en_next_s) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      idx_r   <= (idx_r == IDX_LAST) ? 2'd0 : idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Logical (pre-inversion) pin values for the current digit.
  always_comb begin
    blank_ext_s = ctrl_word_s[11:8];
    dp_ext_s    = ctrl_word_s[19:16];
    an_full_s   = 4'b0001 << idx_r;
    nibble_s    = hex_word_s[{idx_r, 2'b00} +: 4];
    raw_byte_s  = raw_word_s[{idx_r, 3'b000} +: 8];
    an_next_s   = '0;
    seg_next_s  = 7'h00;
    dp_next_s   = 1'b0;
    if (!en_r || blank_ext_s[idx_r]) begin
      an_next_s  = '0;
      seg_next_s = 7'h00;
      dp_next_s  = 1'b0;
    end else if (mode_r) begin
      an_next_s  = an_full_s[NUM_DIGITS-1:0];
      seg_next_s = raw_byte_s[6:0];
      dp_next_s  = raw_byte_s[7];
    end else begin
      an_next_s  = an_full_s[NUM_DIGITS-1:0];
      seg_next_s = hex_decode(nibble_s);
      dp_next_s  = dp_ext_s[idx_r];
    end
  end

  // Registered pins with optional active-low inversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= {7{ACTIVE_LOW}};
      dp_out  <= ACTIVE_LOW;
      an_out  <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg_out <= seg_next_s ^ {7{ACTIVE_LOW}};
      dp_out  <= dp_next_s ^ ACTIVE_LOW;
      an_out  <= an_next_s ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign unused_s = ^{addr[31:4], addr[1:0], an_full_s};

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: a time-based reference model pushes expected
// pins and read data; a negedge monitor pops and compares.
module tb_seg_display_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;

  seg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .wr(wr), .rd(rd), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] an; logic [6:0] seg; logic dp; } pin_t;
  typedef struct { int cyc; logic [31:0] val; } rd_t;
  pin_t pinq[$];
  rd_t  rdq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit done = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: register words plus cycles elapsed since scanning began.
  logic [31:0] m_ctrl = 32'h0;
  logic [31:0] m_hex = 32'h0;
  logic [31:0] m_raw = 32'h0;
  int          m_t = 0;

  function automatic int cur_digit();
    return m_ctrl[0] ? (m_t / SD) % ND : 0;
  endfunction

  function automatic pin_t model_pins();
    pin_t p;
    int d;
    logic [31:0] tmp;
    p.cyc = 0; p.an = 4'h0; p.seg = 7'h00; p.dp = 1'b0;
    d = cur_digit();
    if (m_ctrl[0] && !m_ctrl[8 + d]) begin
      p.an = 4'(1 << d);
      if (m_ctrl[1]) begin
        tmp = m_raw >> (8 * d);
        p.seg = tmp[6:0];
        p.dp = tmp[7];
      end else begin
        tmp = m_hex >> (4 * d);
        p.seg = seg_tab[tmp[3:0]];
        p.dp = m_ctrl[16 + d];
      end
    end
    return p;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'd0: return m_ctrl;
      2'd1: return m_hex;
      2'd2: return m_raw;
      default: return 32'(cur_digit()) | (32'(m_ctrl[0]) << 8);
    endcase
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic old_en;
    if (r) begin
      m_ctrl = 32'h0; m_hex = 32'h0; m_raw = 32'h0; m_t = 0;
    end else begin
      old_en = m_ctrl[0];
      if (w) begin
        case (a[3:2])
          2'd0: m_ctrl = d & 32'h000F_0F03;
          2'd1: m_hex = d & 32'h0000_FFFF;
          2'd2: m_raw = d;
          default: ;
        endcase
      end
      if (old_en && m_ctrl[0]) m_t = m_t + 1;
      else m_t = 0;
    end
  endtask

  // One bus cycle: drive, queue expectations, cross the edge, advance the model.
  task automatic step(input logic r, input logic w, input logic rv, input logic [31:0] a, input logic [31:0] d);
    pin_t p;
    rd_t q;
    rst = r; wr = w; rd = rv; addr = a; data_in = d;
    q.cyc = cyc;
    q.val = rv ? model_read(a) : 32'h0;
    rdq.push_back(q);
    if (r) begin
      p.an = 4'h0; p.seg = 7'h00; p.dp = 1'b0;
    end else begin
      p = model_pins();
    end
    p.cyc = cyc + 1;
    pinq.push_back(p);
    @(posedge clk);
    #1;
    model_update(r, w, a, d);
  endtask

  task automatic idle(input int n, input logic rv, input logic [31:0] a);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rv, a, 32'h0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops entries due this cycle and compares against the pins and read port.
  always @(negedge clk) begin
    if (!done) begin
      while (pinq.size() > 0 && pinq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL pin_missed cyc=%0d due=%0d", cyc, pinq[0].cyc);
        void'(pinq.pop_front());
      end
      if (pinq.size() > 0 && pinq[0].cyc == cyc) begin
        pin_t e;
        e = pinq.pop_front();
        tests++;
        if (an_out !== e.an || seg_out !== e.seg || dp_out !== e.dp) begin
          fails++;
          $display("FAIL pins cyc=%0d an=%b exp=%b seg=%h exp=%h dp=%b exp=%b",
                   cyc, an_out, e.an, seg_out, e.seg, dp_out, e.dp);
        end
      end
      while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL rd_missed cyc=%0d due=%0d", cyc, rdq[0].cyc);
        void'(rdq.pop_front());
      end
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        rd_t e;
        e = rdq.pop_front();
        tests++;
        if (data_out !== e.val) begin
          fails++;
          $display("FAIL data_out cyc=%0d addr=%h got=%h exp=%h", cyc, addr, data_out, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    @(posedge clk);
    #1;
    // Reset with a simultaneous CTRL write, then read CTRL and STATUS.
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0003);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 32'h0);
    // Hex scan.
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0000_A5F0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0001);
    idle(20, 1'b1, 32'hC);
    // Raw mode with decimal points.
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0003);
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'h80FF_0106);
    idle(18, 1'b1, 32'h8);
    // Blanking, then disable mid-frame.
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0501);
    idle(10, 1'b1, 32'hC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(3, 1'b1, 32'hC);
    // Bus behaviour.
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0000_5A5A);
    step(1'b0, 1'b1, 1'b1, 32'h4, 32'h0000_1234);
    step(1'b0, 1'b0, 1'b1, 32'h4, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 32'h4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'hC, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    // Randomized traffic, biased toward keeping the scan enabled.
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0),
           $urandom_range(0, 1) == 1, a, d);
    end
    idle(2, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    done = 1'b1;
    tests++;
    if (pinq.size() != 0 || rdq.size() != 0) begin
      fails++;
      $display("FAIL drain pinq=%0d rdq=%0d exp=0", pinq.size(), rdq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
